// File: rtl/word_serializer_if.sv
// rtl/word_serializer_if.sv - parallel word valid/ready handshake feeding word_serializer
interface word_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - MSB-first parallel-to-serial stage ahead of the shift register
// Optional even parity bit after each frame when SERIALIZER_PARITY_EN is defined.
module word_serializer #(
    parameter int WIDTH    = 4,
    parameter int IDLE_GAP = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Clk_EN,
    word_serializer_if.slave src,
    output logic            ser_out,
    output logic            ser_en,
    output logic            busy,
    output logic            frame_done
);
    localparam int MAXV = (WIDTH > IDLE_GAP) ? WIDTH : IDLE_GAP;
    localparam int CW   = $clog2(MAXV + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LAST = (IDLE_GAP > 0) ? CW'(IDLE_GAP - 1) : '0;

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    gap_cnt;
    logic             done_next;
    logic             accept;
    logic             last_bit;
`ifdef SERIALIZER_PARITY_EN
    logic             parity;
`endif

    // Accept ignores Clk_EN, so the accept cycle never consumes a bit.
    assign accept   = (state == IDLE) && src.din_valid;
    assign last_bit = (state == SHIFT) && Clk_EN && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (src.din_valid) state_next = SHIFT;
            end
            SHIFT: begin
                if (last_bit) begin
`ifdef SERIALIZER_PARITY_EN
                    state_next = PAR;
`else
                    done_next  = 1'b1;
                    state_next = (IDLE_GAP > 0) ? GAP : IDLE;
`endif
                end
            end
`ifdef SERIALIZER_PARITY_EN
            PAR: begin
                if (Clk_EN) begin
                    done_next  = 1'b1;
                    state_next = (IDLE_GAP > 0) ? GAP : IDLE;
                end
            end
`endif
            GAP: begin
                if (Clk_EN && (gap_cnt == GAP_LAST)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            frame_done <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            frame_done <= done_next;
            if (accept) begin
                shreg   <= src.din;
                bit_cnt <= '0;
`ifdef SERIALIZER_PARITY_EN
                parity  <= ^src.din;
`endif
            end else if ((state == SHIFT) && Clk_EN) begin
                shreg   <= {shreg[WIDTH-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if ((state == GAP) && Clk_EN) begin
                gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
            end
        end
    end

    // Ready is held low while reset is asserted so nothing is offered as accepted.
    assign src.din_ready = (state == IDLE) && rst;
    assign busy          = (state != IDLE);
`ifdef SERIALIZER_PARITY_EN
    assign ser_en  = (state == SHIFT) || (state == PAR);
    assign ser_out = (state == SHIFT) ? shreg[WIDTH-1] : ((state == PAR) && parity);
`else
    assign ser_en  = (state == SHIFT);
    assign ser_out = (state == SHIFT) && shreg[WIDTH-1];
`endif
endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - scoreboard bench for word_serializer with downstream shift-register models
module tb_word_serializer;
    localparam int W = 4;
`ifdef SERIALIZER_PARITY_EN
    localparam int FW = W + 1;
`else
    localparam int FW = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic Clk_EN = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   ce_div = 1;
    int   cyc_cnt = 0;

    logic ser_out0, ser_en0, busy0, frame_done0;
    logic ser_out1, ser_en1, busy1, frame_done1;
    logic [FW-1:0] cap0, cap1;
    logic [FW-1:0] sb0[$];
    logic [FW-1:0] sb1[$];

    word_serializer_if #(.WIDTH(W)) if0 ();
    word_serializer_if #(.WIDTH(W)) if1 ();

    word_serializer #(.WIDTH(W), .IDLE_GAP(0)) dut0 (
        .clk(clk), .rst(rst), .Clk_EN(Clk_EN), .src(if0),
        .ser_out(ser_out0), .ser_en(ser_en0), .busy(busy0), .frame_done(frame_done0)
    );

    word_serializer #(.WIDTH(W), .IDLE_GAP(2)) dut1 (
        .clk(clk), .rst(rst), .Clk_EN(Clk_EN), .src(if1),
        .ser_out(ser_out1), .ser_en(ser_en1), .busy(busy1), .frame_done(frame_done1)
    );

    always #5 clk = ~clk;

    // Downstream shift registers: in=ser_out, en=ser_en, shifting on Clk_EN.
    always @(posedge clk) begin
        if (ser_en0 && Clk_EN) cap0 <= {cap0[FW-2:0], ser_out0};
        if (ser_en1 && Clk_EN) cap1 <= {cap1[FW-2:0], ser_out1};
    end

    function automatic logic [FW-1:0] exp_frame(input logic [W-1:0] w);
`ifdef SERIALIZER_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc_cnt++;
        Clk_EN = ((cyc_cnt % ce_div) == 0);
    endtask

    task automatic test_reset();
        if0.din = '0; if0.din_valid = 1'b0;
        if1.din = '0; if1.din_valid = 1'b0;
        rst = 1'b0; Clk_EN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy0, ser_en0, ser_out0, frame_done0} !== 4'b0000) begin
            errors++; $display("FAIL reset_out0: busy/en/out/done=%b required 0000", {busy0, ser_en0, ser_out0, frame_done0});
        end
        checks++;
        if ({busy1, ser_en1, ser_out1, frame_done1} !== 4'b0000) begin
            errors++; $display("FAIL reset_out1: busy/en/out/done=%b required 0000", {busy1, ser_en1, ser_out1, frame_done1});
        end
        checks++;
        if ({if0.din_ready, if1.din_ready} !== 2'b11) begin
            errors++; $display("FAIL reset_ready: got %b required 11", {if0.din_ready, if1.din_ready});
        end
    endtask

    task automatic test_serial(input logic [W-1:0] word, input int div);
        logic [FW-1:0] ef;
        logic [FW-1:0] want;
        int  idx;
        int  en_cyc;
        bit  done;
        ef = exp_frame(word);
        idx = 0; en_cyc = 0; done = 1'b0;
        ce_div = div; cyc_cnt = 0; Clk_EN = 1'b1;
        if0.din = word; if0.din_valid = 1'b1;
        sb0.push_back(ef);
        step();
        if0.din_valid = 1'b0;
        if0.din = ~word;
        for (int c = 0; c < 200 && !done; c++) begin
            if (frame_done0) begin
                done = 1'b1;
            end else begin
                if (ser_en0) begin
                    checks++;
                    if (idx >= FW || ser_out0 !== ef[FW-1-idx]) begin
                        errors++; $display("FAIL serial_bit: word %b bit %0d got %b", word, idx, ser_out0);
                    end
                    en_cyc++;
                    if (Clk_EN) idx++;
                end
                step();
            end
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL frame_done_timeout: word %b no frame_done, required one", word);
        end
        checks++;
        if (en_cyc !== div * FW) begin
            errors++; $display("FAIL ser_en_cycles: word %b got %0d required %0d", word, en_cyc, div * FW);
        end
        checks++;
        want = (sb0.size() > 0) ? sb0.pop_front() : ~ef;
        if (cap0 !== want) begin
            errors++; $display("FAIL capture: got %b required %b", cap0, want);
        end
        checks++;
        if (ser_en0 !== 1'b0 || if0.din_ready !== 1'b1) begin
            errors++; $display("FAIL post_frame: ser_en=%b din_ready=%b required 0,1", ser_en0, if0.din_ready);
        end
        step();
        checks++;
        if (frame_done0 !== 1'b0) begin
            errors++; $display("FAIL frame_done_pulse: got %b required 0 one cycle later", frame_done0);
        end
    endtask

    task automatic test_ignore();
        logic [FW-1:0] want;
        int frames;
        bit bad_ready;
        frames = 0; bad_ready = 1'b0;
        ce_div = 1; cyc_cnt = 0; Clk_EN = 1'b1;
        if0.din = 4'h5; if0.din_valid = 1'b1;
        sb0.push_back(exp_frame(4'h5));
        step();
        if0.din = 4'hF;
        sb0.push_back(exp_frame(4'hF));
        for (int c = 0; c < 100 && frames < 2; c++) begin
            if (frame_done0) begin
                frames++;
                want = (sb0.size() > 0) ? sb0.pop_front() : ~cap0;
                checks++;
                if (cap0 !== want) begin
                    errors++; $display("FAIL ignore_capture%0d: got %b required %b", frames, cap0, want);
                end
                if (frames == 1) begin
                    checks++;
                    if (if0.din_ready !== 1'b1) begin
                        errors++; $display("FAIL ignore_ready_after: got %b required 1", if0.din_ready);
                    end
                end
            end
            if (busy0 && if0.din_ready !== 1'b0) bad_ready = 1'b1;
            step();
            if (frames == 1) if0.din_valid = 1'b0;
        end
        checks++;
        if (frames !== 2) begin
            errors++; $display("FAIL ignore_frames: got %0d required 2", frames);
        end
        checks++;
        if (bad_ready !== 1'b0) begin
            errors++; $display("FAIL ignore_ready_busy: din_ready high while busy, required 0");
        end
        step();
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        saw_done = 1'b0;
        ce_div = 1; cyc_cnt = 0; Clk_EN = 1'b1;
        if0.din = 4'b1100; if0.din_valid = 1'b1;
        step();
        if0.din_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({ser_en0, busy0, ser_out0, frame_done0} !== 4'b0000) begin
            errors++; $display("FAIL abort_outputs: en/busy/out/done=%b required 0000", {ser_en0, busy0, ser_out0, frame_done0});
        end
        step();
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (if0.din_ready !== 1'b1) begin
            errors++; $display("FAIL abort_ready: got %b required 1", if0.din_ready);
        end
        repeat (6) begin
            step();
            if (frame_done0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++; $display("FAIL abort_frame_done: frame_done seen after abort, required none");
        end
        test_serial(4'b1001, 1);
    endtask

    task automatic test_gap();
        logic [FW-1:0] want;
        int frames;
        int gap_ticks;
        bit bad_ready;
        bit acc;
        frames = 0; gap_ticks = 0; bad_ready = 1'b0;
        ce_div = 2; cyc_cnt = 0; Clk_EN = 1'b1;
        if1.din = 4'h9; if1.din_valid = 1'b1;
        sb1.push_back(exp_frame(4'h9));
        step();
        if1.din = 4'h3;
        sb1.push_back(exp_frame(4'h3));
        for (int c = 0; c < 300 && frames < 2; c++) begin
            if (frame_done1) begin
                frames++;
                want = (sb1.size() > 0) ? sb1.pop_front() : ~cap1;
                checks++;
                if (cap1 !== want) begin
                    errors++; $display("FAIL gap_capture%0d: got %b required %b", frames, cap1, want);
                end
            end
            if (frames < 2) begin
                if (busy1 && if1.din_ready !== 1'b0) bad_ready = 1'b1;
                if (busy1 && !ser_en1 && Clk_EN) gap_ticks++;
                acc = if1.din_ready && if1.din_valid;
                step();
                if (acc) if1.din_valid = 1'b0;
            end
        end
        checks++;
        if (frames !== 2) begin
            errors++; $display("FAIL gap_frames: got %0d required 2", frames);
        end
        checks++;
        if (gap_ticks !== 2) begin
            errors++; $display("FAIL gap_ticks: got %0d required 2", gap_ticks);
        end
        checks++;
        if (bad_ready !== 1'b0) begin
            errors++; $display("FAIL gap_ready_busy: din_ready high while busy, required 0");
        end
        if1.din_valid = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        test_reset();
        test_serial(4'b1011, 1);
        test_serial(4'b0110, 3);
        test_ignore();
        test_reset_mid();
        test_gap();
`ifdef SERIALIZER_PARITY_EN
        test_serial(4'b0111, 1);
`endif
        test_serial(4'b0000, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
